// File: rtl/ysyx_22051013_bpu_bht.sv
// Dynamic branch predictor for the IF stage: a flop-based table of 2-bit
// saturating counters, indexed by PC (bimodal) or PC xor global history
// (gshare). Prediction is combinational. EXU trains one entry per cycle.
module ysyx_22051013_bpu_bht #(
    parameter int         IDX_W    = 6,
    parameter int         MODE     = 0,
    parameter int         HIST_W   = 6,
    parameter logic [1:0] INIT_CNT = 2'b01
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       inst,
    input  logic [63:0]       pc_i,
    output logic [63:0]       pc_o,
    output logic              bpu_jump,
    output logic [IDX_W-1:0]  pred_idx,
    input  logic              upd_valid,
    input  logic [IDX_W-1:0]  upd_idx,
    input  logic              upd_taken,
    input  logic              upd_mispred,
    output logic [31:0]       mispred_cnt
);

    localparam int DEPTH = 2 ** IDX_W;

    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_BRANCH = 5'b11000;

    // One step of a 2-bit saturating counter toward the observed outcome.
    function automatic logic [1:0] sat_step(input logic [1:0] c, input logic taken);
        logic [1:0] r;
        r = c;
        if (taken) begin
            if (c != 2'b11) r = c + 2'd1;
        end else begin
            if (c != 2'b00) r = c - 2'd1;
        end
        return r;
    endfunction

    // Event counter that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
    endfunction

    logic [1:0]       cnt [DEPTH];
    logic [31:0]      mispred_q;
    logic [IDX_W-1:0] hist_ext;
    logic [IDX_W-1:0] idx;
    logic             is_jal;
    logic             is_bxx;
    logic [63:0]      imm_j;
    logic [63:0]      imm_b;

    // Global history only exists in gshare mode; bimodal hashes with zero.
    generate
        if (MODE == 1) begin : g_gshare
            logic [HIST_W-1:0] ghr;

            // History shift register, fed by every resolved branch outcome.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ghr <= '0;
                end else if (upd_valid) begin
                    if (HIST_W == 1) begin
                        ghr <= HIST_W'(upd_taken);
                    end else begin
                        ghr <= HIST_W'({ghr, upd_taken});
                    end
                end
            end

            assign hist_ext = IDX_W'(ghr);
        end else begin : g_bimodal
            assign hist_ext = '0;
        end
    endgenerate

    // Decode, immediates and table index for the instruction in IF.
    always_comb begin
        is_jal = (inst[6:2] == OP_JAL)    && (inst[1:0] == 2'b11);
        is_bxx = (inst[6:2] == OP_BRANCH) && (inst[1:0] == 2'b11);
        imm_j  = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        imm_b  = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        idx    = pc_i[IDX_W+1:2] ^ hist_ext;
    end

    // Next-PC selection; reset forces all prediction outputs to zero.
    // The table is read before any same-cycle update lands (no bypass).
    always_comb begin
        pc_o     = pc_i + 64'd4;
        bpu_jump = 1'b0;
        pred_idx = idx;
        if (rst) begin
            pc_o     = '0;
            bpu_jump = 1'b0;
            pred_idx = '0;
        end else if (is_jal) begin
            pc_o = pc_i + imm_j;
        end else if (is_bxx && cnt[idx][1]) begin
            pc_o     = pc_i + imm_b;
            bpu_jump = 1'b1;
        end
    end

    // Counter table training; reset restores every entry and drops the update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt[i] <= INIT_CNT;
            end
        end else if (upd_valid) begin
            cnt[upd_idx] <= sat_step(cnt[upd_idx], upd_taken);
        end
    end

    // Misprediction statistics counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            mispred_q <= '0;
        end else if (upd_valid && upd_mispred) begin
            mispred_q <= sat_inc32(mispred_q);
        end
    end

    assign mispred_cnt = mispred_q;

endmodule

// File: tb/tb_ysyx_22051013_bpu_bht.sv
// Directed bench for the branch history table: a bimodal instance and a
// gshare instance (HIST_W=2) share clock, reset and the IF-side inputs.
module tb_ysyx_22051013_bpu_bht;

    localparam logic [31:0] BEQ_P20  = 32'h0200_0063; // beq x0,x0,+0x20
    localparam logic [31:0] JAL_M100 = 32'hF01F_F06F; // jal x0,-0x100
    localparam logic [31:0] ADDI_NOP = 32'h0000_0013;
    localparam logic [31:0] BAD_BR   = 32'h0200_0060; // branch opcode, bits[1:0]=00

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst;
    logic [63:0] pc_i;

    logic [63:0] pc_o0, pc_o1;
    logic        jump0, jump1;
    logic [5:0]  pidx0;
    logic [5:0]  pidx1;
    logic [31:0] mcnt0, mcnt1;

    logic        upd_valid0, upd_taken0, upd_mispred0;
    logic [5:0]  upd_idx0;
    logic        upd_valid1, upd_taken1, upd_mispred1;
    logic [5:0]  upd_idx1;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ysyx_22051013_bpu_bht #(.IDX_W(6), .MODE(0), .HIST_W(6), .INIT_CNT(2'b01)) dut0 (
        .clk(clk), .rst(rst), .inst(inst), .pc_i(pc_i),
        .pc_o(pc_o0), .bpu_jump(jump0), .pred_idx(pidx0),
        .upd_valid(upd_valid0), .upd_idx(upd_idx0), .upd_taken(upd_taken0),
        .upd_mispred(upd_mispred0), .mispred_cnt(mcnt0)
    );

    ysyx_22051013_bpu_bht #(.IDX_W(6), .MODE(1), .HIST_W(2), .INIT_CNT(2'b01)) dut1 (
        .clk(clk), .rst(rst), .inst(inst), .pc_i(pc_i),
        .pc_o(pc_o1), .bpu_jump(jump1), .pred_idx(pidx1),
        .upd_valid(upd_valid1), .upd_idx(upd_idx1), .upd_taken(upd_taken1),
        .upd_mispred(upd_mispred1), .mispred_cnt(mcnt1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd0(input logic v, input logic [5:0] i, input logic t, input logic m);
        upd_valid0 = v; upd_idx0 = i; upd_taken0 = t; upd_mispred0 = m;
    endtask

    initial begin
        rst  = 1'b1;
        inst = BEQ_P20;
        pc_i = 64'h8000_0010;
        upd0(1'b0, 6'd0, 1'b0, 1'b0);
        upd_valid1 = 1'b0; upd_idx1 = 6'd0; upd_taken1 = 1'b0; upd_mispred1 = 1'b0;
        #1;
        // Combinational override while reset is held
        check("rst_pc_o",   pc_o0, 64'h0);
        check("rst_jump",   {63'h0, jump0}, 64'h0);
        check("rst_idx",    {58'h0, pidx0}, 64'h0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_mcnt",   {32'h0, mcnt0}, 64'h0);
        // Test 1: weakly not-taken after reset
        check("t1_pc_o",    pc_o0, 64'h8000_0014);
        check("t1_jump",    {63'h0, jump0}, 64'h0);
        check("t1_idx",     {58'h0, pidx0}, 64'd4);
        check("t1_gs_idx",  {58'h0, pidx1}, 64'd4);

        // Test 2: train idx 4 upward, saturate, then back down
        upd0(1'b1, 6'd4, 1'b1, 1'b0);
        tick(); // 10
        check("t2_cnt10_pc", pc_o0, 64'h8000_0030);
        check("t2_cnt10_jump", {63'h0, jump0}, 64'h1);
        tick(); // 11
        check("t2_cnt11_jump", {63'h0, jump0}, 64'h1);
        tick(); tick(); tick(); // stays 11
        upd0(1'b1, 6'd4, 1'b0, 1'b0);
        tick(); // 10
        check("t2_dn10_jump", {63'h0, jump0}, 64'h1);
        tick(); // 01
        check("t2_dn01_jump", {63'h0, jump0}, 64'h0);
        check("t2_dn01_pc",   pc_o0, 64'h8000_0014);
        tick(); // 00
        check("t2_dn00_jump", {63'h0, jump0}, 64'h0);
        tick(); // stays 00
        upd0(1'b1, 6'd4, 1'b1, 1'b0);
        tick(); // 01
        check("t2_up01_jump", {63'h0, jump0}, 64'h0);
        upd0(1'b0, 6'd4, 1'b1, 1'b1);
        tick(); // ignored, still 01
        check("t2_novld_jump", {63'h0, jump0}, 64'h0);
        check("t2_novld_mcnt", {32'h0, mcnt0}, 64'h0);

        // Test 3: JAL always redirects without bpu_jump
        inst = JAL_M100;
        pc_i = 64'h8000_0100;
        #1;
        check("t3_jal_pc",   pc_o0, 64'h8000_0000);
        check("t3_jal_jump", {63'h0, jump0}, 64'h0);

        // Non-branch and malformed opcode fall through to +4
        inst = ADDI_NOP;
        pc_i = 64'h8000_0010;
        #1;
        check("nb_pc",  pc_o0, 64'h8000_0014);
        check("nb_idx", {58'h0, pidx0}, 64'd4);

        // Test 4: same-cycle read and update of idx 4 (counter 01)
        inst = BEQ_P20;
        upd0(1'b1, 6'd4, 1'b1, 1'b0);
        #1;
        check("t4_same_jump", {63'h0, jump0}, 64'h0);
        tick(); // 10
        upd0(1'b0, 6'd0, 1'b0, 1'b0);
        #1;
        check("t4_next_jump", {63'h0, jump0}, 64'h1);
        inst = BAD_BR;
        #1;
        check("bad_op_pc",   pc_o0, 64'h8000_0014);
        check("bad_op_jump", {63'h0, jump0}, 64'h0);
        inst = BEQ_P20;

        // Test 5: gshare history 01 then 10
        upd_valid1 = 1'b1; upd_idx1 = 6'd9; upd_taken1 = 1'b1;
        tick();
        check("t5_ghr01_idx", {58'h0, pidx1}, 64'd5);
        upd_taken1 = 1'b0;
        tick();
        upd_valid1 = 1'b0; upd_taken1 = 1'b1;
        tick();
        check("t5_ghr10_idx", {58'h0, pidx1}, 64'd6);
        check("t5_bimodal_idx", {58'h0, pidx0}, 64'd4);

        // Test 6: misprediction count, then reset with a concurrent update
        upd0(1'b1, 6'd10, 1'b1, 1'b1);
        repeat (5) tick();
        check("t6_mcnt5", {32'h0, mcnt0}, 64'd5);
        upd0(1'b0, 6'd10, 1'b1, 1'b1);
        tick();
        check("t6_mcnt_hold", {32'h0, mcnt0}, 64'd5);
        rst = 1'b1;
        upd0(1'b1, 6'd4, 1'b1, 1'b1);
        upd_valid1 = 1'b1; upd_taken1 = 1'b1;
        tick();
        rst = 1'b0;
        upd0(1'b0, 6'd0, 1'b0, 1'b0);
        upd_valid1 = 1'b0; upd_taken1 = 1'b0;
        #1;
        check("t6_mcnt_rst", {32'h0, mcnt0}, 64'd0);
        check("t6_idx4_init", {63'h0, jump0}, 64'h0);
        check("t6_ghr_rst", {58'h0, pidx1}, 64'd4);
        pc_i = 64'h8000_0028;
        #1;
        check("t6_idx10_init", {63'h0, jump0}, 64'h0);
        pc_i = 64'h8000_0010;
        upd0(1'b1, 6'd4, 1'b1, 1'b0);
        tick(); // 01 -> 10 only if reset left it at INIT and dropped the update
        upd0(1'b0, 6'd0, 1'b0, 1'b0);
        #1;
        check("t6_after_one", {63'h0, jump0}, 64'h1);

        // Saturation of the misprediction counter near its maximum
        force dut0.mispred_q = 32'hFFFF_FFFE;
        #1;
        release dut0.mispred_q;
        upd0(1'b1, 6'd1, 1'b0, 1'b1);
        tick();
        check("t6_sat_max", {32'h0, mcnt0}, 64'hFFFF_FFFF);
        tick();
        check("t6_sat_hold", {32'h0, mcnt0}, 64'hFFFF_FFFF);
        upd0(1'b0, 6'd0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
